vga_sincronizador: RTL and testbench

- Raster timing generator for the 640x480@60 Hz VGA path.
- Sits directly upstream of the obstacle/shape drawing blocks (horizontal-bar drawer, etc.), which consume its xCol/yRow to decide whether to draw the current pixel.
- Also drives the monitor's hsync/vsync pins and a blanking qualifier.
- Emits per-line and per-frame tick pulses that game/movement logic uses to update object coordinates once per frame.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/contador_modulo.sv | 48 ++++
 rtl/vga_sincronizador.sv | 127 ++++++++++++
 tb/tb_vga_sincronizador.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : 640x480@60 Hz timing set, derived totals and coordinate widths.
// Rev     : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int unsigned c_H_VISIBLE = 640;
    localparam int unsigned c_H_FP      = 16;
    localparam int unsigned c_H_SYNC    = 96;
    localparam int unsigned c_H_BP      = 48;
    localparam int unsigned c_V_VISIBLE = 480;
    localparam int unsigned c_V_FP      = 10;
    localparam int unsigned c_V_SYNC    = 2;
    localparam int unsigned c_V_BP      = 33;

    localparam int unsigned c_H_TOTAL = c_H_VISIBLE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int unsigned c_V_TOTAL = c_V_VISIBLE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int unsigned COL_W     = 10;
    localparam int unsigned ROW_W     = 9;
    localparam int unsigned c_V_CNT_W = 10;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/contador_modulo.sv
`default_nettype none
// ============================================================================
// Module  : contador_modulo
// Purpose : Enabled modulo-MODULO wrap counter exposing its next value.
// Rev     : 1.0  initial release
// ============================================================================
module contador_modulo #(
    parameter int unsigned MODULO = 800,
    parameter int unsigned WIDTH  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count_next,
    output logic             o_last_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_at_last;

    assign w_at_last = (r_count == c_LAST);

    always_comb begin
        w_next = r_count;
        if (i_en) begin
            w_next = w_at_last ? '0 : r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    // Next-value taps let the owner register outputs aligned with the count.
    assign o_count_next = w_next;
    assign o_last_next  = (w_next == c_LAST);
    assign o_wrap       = i_en & w_at_last;

endmodule : contador_modulo
`default_nettype wire

// File: rtl/vga_sincronizador.sv
`default_nettype none
// ============================================================================
// Module  : vga_sincronizador
// Purpose : VGA raster timing: coordinates, syncs, blanking, line/frame ticks.
//           VGA_SYNC_PIX_DIV2_EN: VGA_clk is 2x pixel rate, enable every 2nd clk.
// Rev     : 1.0  initial release
// ============================================================================
module vga_sincronizador
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = c_H_VISIBLE,
    parameter int unsigned H_FP        = c_H_FP,
    parameter int unsigned H_SYNC      = c_H_SYNC,
    parameter int unsigned H_BP        = c_H_BP,
    parameter int unsigned V_VISIBLE   = c_V_VISIBLE,
    parameter int unsigned V_FP        = c_V_FP,
    parameter int unsigned V_SYNC      = c_V_SYNC,
    parameter int unsigned V_BP        = c_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic             VGA_clk,
    input  logic             rst_n,
    output logic [COL_W-1:0] xCol,
    output logic [ROW_W-1:0] yRow,
    output logic             hsync,
    output logic             vsync,
    output logic             displayArea,
    output logic             line_tick,
    output logic             frame_tick
);

    localparam int unsigned c_H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [COL_W-1:0]     c_H_VIS    = COL_W'(H_VISIBLE);
    localparam logic [COL_W-1:0]     c_HS_START = COL_W'(H_VISIBLE + H_FP);
    localparam logic [COL_W-1:0]     c_HS_END   = COL_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [c_V_CNT_W-1:0] c_V_VIS    = c_V_CNT_W'(V_VISIBLE);
    localparam logic [c_V_CNT_W-1:0] c_VS_START = c_V_CNT_W'(V_VISIBLE + V_FP);
    localparam logic [c_V_CNT_W-1:0] c_VS_END   = c_V_CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    generate
        if ((c_H_TOT > (1 << COL_W)) || (c_V_TOT > (1 << c_V_CNT_W))) begin : g_width_check
            $error("vga_sincronizador: timing totals do not fit the 10-bit counters");
        end
    endgenerate

    logic w_pix_en;

`ifdef VGA_SYNC_PIX_DIV2_EN
    logic r_pix_toggle;

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_toggle <= 1'b0;
        end else begin
            r_pix_toggle <= ~r_pix_toggle;
        end
    end

    assign w_pix_en = r_pix_toggle;
`else
    assign w_pix_en = 1'b1;
`endif

    logic [COL_W-1:0]     w_h_next;
    logic [c_V_CNT_W-1:0] w_v_next;
    logic                 w_h_last_next;
    logic                 w_v_last_next;
    logic                 w_h_wrap;
    logic                 w_unused_v_wrap;

    contador_modulo #(
        .MODULO (c_H_TOT),
        .WIDTH  (COL_W)
    ) u_h_cnt (
        .clk          (VGA_clk),
        .rst_n        (rst_n),
        .i_en         (w_pix_en),
        .o_count_next (w_h_next),
        .o_last_next  (w_h_last_next),
        .o_wrap       (w_h_wrap)
    );

    contador_modulo #(
        .MODULO (c_V_TOT),
        .WIDTH  (c_V_CNT_W)
    ) u_v_cnt (
        .clk          (VGA_clk),
        .rst_n        (rst_n),
        .i_en         (w_h_wrap),
        .o_count_next (w_v_next),
        .o_last_next  (w_v_last_next),
        .o_wrap       (w_unused_v_wrap)
    );

    logic w_v_vis_next;
    logic w_hs_next;
    logic w_vs_next;

    assign w_v_vis_next = (w_v_next < c_V_VIS);
    assign w_hs_next    = (w_h_next >= c_HS_START) && (w_h_next < c_HS_END);
    assign w_vs_next    = (w_v_next >= c_VS_START) && (w_v_next < c_VS_END);

    // Outputs are decoded from next counts so they land with xCol, zero skew.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            xCol        <= '0;
            yRow        <= '0;
            displayArea <= 1'b1;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            xCol        <= w_h_next;
            yRow        <= w_v_vis_next ? w_v_next[ROW_W-1:0] : '0;
            displayArea <= (w_h_next < c_H_VIS) && w_v_vis_next;
            hsync       <= w_hs_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= w_vs_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            line_tick   <= w_h_last_next;
            frame_tick  <= w_h_last_next && w_v_last_next;
        end
    end

endmodule : vga_sincronizador
`default_nettype wire

// File: tb/tb_vga_sincronizador.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sincronizador
// Purpose : Scoreboard bench; full horizontal timing, shortened frame (15 lines).
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_sincronizador;

`ifdef VGA_SYNC_PIX_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int HT = 800;
    localparam int VT = 15;
    localparam int FR = HT * VT;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] xCol;
    logic [8:0] yRow;
    logic       hsync, vsync, displayArea, line_tick, frame_tick;

    vga_sincronizador #(
        .V_VISIBLE (8),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (3)
    ) dut (
        .VGA_clk     (clk),
        .rst_n       (rst_n),
        .xCol        (xCol),
        .yRow        (yRow),
        .hsync       (hsync),
        .vsync       (vsync),
        .displayArea (displayArea),
        .line_tick   (line_tick),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          k;
        logic [23:0] exp;
    } vec_t;

    vec_t q[$];
    vec_t mv;
    int   n_vec = 0;
    int   n_bad = 0;
    int   k     = 0;
    bit   phase1 = 1'b0;

    int hs_low = 0, vs_low = 0, lt_hi = 0, ft_hi = 0, y_zero = 0, hs_bad = 0;
    int lt_rises = 0, lt_badper = 0, lt_last = -1, ft_n = 0;
    int ft_t[3];
    bit lt_prev = 1'b0, ft_prev = 1'b0;

    function automatic logic [23:0] snap(input int x, input int y, input bit da,
                                         input bit hs, input bit vs, input bit lt, input bit ft);
        return {10'(x), 9'(y), da, hs, vs, lt, ft};
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input string name, input int p, input int x, input int y, input bit da,
                        input bit hs, input bit vs, input bit lt, input bit ft);
        vec_t v;
        v.name = name;
        v.k    = DIV * p + DIV - 1;
        v.exp  = snap(x, y, da, hs, vs, lt, ft);
        q.push_back(v);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d vectors pending, required 0", q.size());
            q.delete();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Scoreboard monitor: pops the head vector on the clock it is due.
    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            if (q[0].k == k) begin
                mv = q.pop_front();
                cmp(mv.name, int'({xCol, yRow, displayArea, hsync, vsync, line_tick, frame_tick}),
                    int'(mv.exp));
            end else if (q[0].k < k) begin
                mv = q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL %s: sample clock %0d missed, now %0d", mv.name, mv.k, k);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && phase1) begin
            if (k < FR * DIV) begin
                hs_low += int'(!hsync);
                vs_low += int'(!vsync);
                lt_hi  += int'(line_tick);
                ft_hi  += int'(frame_tick);
                y_zero += int'(yRow == 9'd0);
                hs_bad += int'(!hsync && (xCol < 10'd656 || xCol > 10'd751));
            end
            if (line_tick && !lt_prev) begin
                if (lt_last >= 0 && (k - lt_last) != HT * DIV) lt_badper++;
                lt_last = k;
                if (k < 3 * FR * DIV) lt_rises++;
            end
            if (frame_tick && !ft_prev) begin
                if (ft_n < 3) ft_t[ft_n] = k;
                ft_n++;
            end
            lt_prev = line_tick;
            ft_prev = frame_tick;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_hold", int'({xCol, yRow, displayArea, hsync, vsync, line_tick, frame_tick}),
            int'(snap(0, 0, 1, 1, 1, 0, 0)));

        //   name           pixel   x    y  da hs vs lt ft
        push("px0",             0,   0,  0, 1, 1, 1, 0, 0);
        push("px1",             1,   1,  0, 1, 1, 1, 0, 0);
        push("last_visible",  639, 639,  0, 1, 1, 1, 0, 0);
        push("first_blank",   640, 640,  0, 0, 1, 1, 0, 0);
        push("fp_end",        655, 655,  0, 0, 1, 1, 0, 0);
        push("hs_start",      656, 656,  0, 0, 0, 1, 0, 0);
        push("hs_end",        751, 751,  0, 0, 0, 1, 0, 0);
        push("hs_release",    752, 752,  0, 0, 1, 1, 0, 0);
        push("line_end",      799, 799,  0, 0, 1, 1, 1, 0);
        push("row1_start",    800,   0,  1, 1, 1, 1, 0, 0);
        push("last_row",     5605,   5,  7, 1, 1, 1, 0, 0);
        push("row8_forced0", 6405,   5,  0, 0, 1, 1, 0, 0);
        push("row9_end",     7999, 799,  0, 0, 1, 1, 1, 0);
        push("vs_start",     8000,   0,  0, 0, 1, 0, 0, 0);
        push("both_sync",    8656, 656,  0, 0, 0, 0, 0, 0);
        push("vs_last",      9599, 799,  0, 0, 1, 0, 1, 0);
        push("vs_release",   9600,   0,  0, 0, 1, 1, 0, 0);
        push("frame_end",   11999, 799,  0, 0, 1, 1, 1, 1);
        push("frame1_start",12000,   0,  0, 1, 1, 1, 0, 0);
        push("pre_reset",   38700, 300,  3, 1, 1, 1, 0, 0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        phase1 = 1'b1;
        drain(DIV * 40000);
        phase1 = 1'b0;

        cmp("hsync_low_clocks",  hs_low, 1440 * DIV);
        cmp("hsync_low_outside", hs_bad, 0);
        cmp("vsync_low_clocks",  vs_low, 1600 * DIV);
        cmp("line_tick_clocks",  lt_hi,  15 * DIV);
        cmp("frame_tick_clocks", ft_hi,  DIV);
        cmp("yrow_zero_clocks",  y_zero, 6400 * DIV);
        cmp("line_tick_count",   lt_rises, 45);
        cmp("line_tick_period",  lt_badper, 0);
        cmp("frame_tick_count",  ft_n, 3);
        cmp("frame_tick_first",  ft_t[0], DIV * 11999);
        cmp("frame_period_1",    ft_t[1] - ft_t[0], FR * DIV);
        cmp("frame_period_2",    ft_t[2] - ft_t[1], FR * DIV);

        #1 rst_n = 1'b0;
        #1;
        cmp("async_reset", int'({xCol, yRow, displayArea, hsync, vsync, line_tick, frame_tick}),
            int'(snap(0, 0, 1, 1, 1, 0, 0)));
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_held", int'({xCol, yRow, displayArea, hsync, vsync, line_tick, frame_tick}),
            int'(snap(0, 0, 1, 1, 1, 0, 0)));

        push("restart_px0",     0,   0,  0, 1, 1, 1, 0, 0);
        push("restart_px1",     1,   1,  0, 1, 1, 1, 0, 0);
        push("restart_x300",  300, 300,  0, 1, 1, 1, 0, 0);
        push("restart_row1",  800,   0,  1, 1, 1, 1, 0, 0);
        push("restart_x200", 1000, 200,  1, 1, 1, 1, 0, 0);
        #1 rst_n = 1'b1;
        drain(DIV * 1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_vga_sincronizador
`default_nettype wire
